// File: rtl/io_output_pkg.sv
// io_output_pkg: shared I/O address codes (addr[7:2]) and STATUS bit positions.
package io_output_pkg;
  localparam logic [5:0] A_PORT0  = 6'b100000;
  localparam logic [5:0] A_PORT1  = 6'b100001;
  localparam logic [5:0] A_PORT2  = 6'b100010;
  localparam logic [5:0] A_STATUS = 6'b100011;
  localparam logic [5:0] A_INPUT  = 6'b100100;
  localparam int ST_VALID_LSB = 0;
  localparam int ST_OVR_LSB   = 4;
  localparam int N_PORTS      = 3;
endpackage

// File: rtl/io_output_if.sv
// io_output_if: CPU store/readback bus plus the three output-port handshakes.
interface io_output_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        io_we;
  logic [31:0] io_read_data;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [2:0]  out_valid;
  logic [2:0]  out_ack;
  modport master (
    output addr, wdata, io_we, out_ack,
    input  io_read_data, out_port0, out_port1, out_port2, out_valid
  );
  modport slave (
    input  addr, wdata, io_we, out_ack,
    output io_read_data, out_port0, out_port1, out_port2, out_valid
  );
endinterface

// File: rtl/io_out_chan.sv
// io_out_chan: one output port -- data register, pending flag and sticky overrun.
module io_out_chan #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic        i_ack,
  input  logic        i_clr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_overrun
);
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_ovr;
  // a fresh overrun wins over a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= RST_VAL;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (i_we) r_data <= i_wdata;
      r_valid <= i_we | (r_valid & ~i_ack);
      r_ovr   <= (i_we & r_valid & ~i_ack) | (r_ovr & ~i_clr);
    end
  end
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;
endmodule

// File: rtl/io_output.sv
// io_output: memory-mapped output ports -- address decode, readback mux and STATUS.
module io_output
  import io_output_pkg::*;
#(
  parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
  input logic        io_clk,
  input logic        reset,
  io_output_if.slave bus
);
  logic [5:0]  w_sel;
  logic [2:0]  w_we;
  logic [2:0]  w_clr;
  logic [2:0]  w_valid;
  logic [2:0]  w_ovr;
  logic [31:0] w_data [N_PORTS];
  logic [31:0] w_status;
  assign w_sel = bus.addr[7:2];
  assign w_clr = (bus.io_we && w_sel == A_STATUS) ? bus.wdata[ST_OVR_LSB +: 3] : 3'b000;
  genvar g;
  for (g = 0; g < N_PORTS; g++) begin : g_chan
    assign w_we[g] = bus.io_we && (w_sel == A_PORT0 + 6'(g));
    io_out_chan #(.RST_VAL(OUT_RESET)) u_chan (
      .clk      (io_clk),
      .rst      (reset),
      .i_we     (w_we[g]),
      .i_ack    (bus.out_ack[g]),
      .i_clr    (w_clr[g]),
      .i_wdata  (bus.wdata),
      .o_data   (w_data[g]),
      .o_valid  (w_valid[g]),
      .o_overrun(w_ovr[g])
    );
  end
  always_comb begin
    w_status = 32'h0;
    w_status[ST_VALID_LSB +: 3] = w_valid;
    w_status[ST_OVR_LSB +: 3]   = w_ovr;
  end
  assign bus.out_port0 = w_data[0];
  assign bus.out_port1 = w_data[1];
  assign bus.out_port2 = w_data[2];
  assign bus.out_valid = w_valid;
  assign bus.io_read_data = (w_sel == A_PORT0)  ? w_data[0] :
                            (w_sel == A_PORT1)  ? w_data[1] :
                            (w_sel == A_PORT2)  ? w_data[2] :
                            (w_sel == A_STATUS) ? w_status  : 32'h0;
endmodule

// File: tb/tb_io_output.sv
// tb_io_output: directed and randomized checks of io_output against a port-level model.
module tb_io_output;
  localparam logic [31:0] RV = 32'hC0DE_0F0F;
  logic io_clk = 1'b0;
  logic reset  = 1'b1;
  io_output_if bus();
  io_output #(.OUT_RESET(RV)) dut (.io_clk(io_clk), .reset(reset), .bus(bus));
  always #5 io_clk = ~io_clk;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_data [3];
  logic [2:0]  m_valid;
  logic [2:0]  m_ovr;
  function automatic logic [31:0] exp_status();
    return {25'b0, m_ovr, 1'b0, m_valid};
  endfunction
  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int p;
    p = int'(a[7:2]);
    if (p >= 32 && p <= 34) return m_data[p - 32];
    if (p == 35) return exp_status();
    return 32'h0;
  endfunction
  function automatic logic [98:0] exp_state();
    return {m_data[0], m_data[1], m_data[2], m_valid};
  endfunction
  function automatic logic [98:0] got_state();
    return {bus.out_port0, bus.out_port1, bus.out_port2, bus.out_valid};
  endfunction
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [2:0] ack, input logic rst);
    int p;
    reset = rst; bus.addr = a; bus.wdata = d; bus.io_we = we; bus.out_ack = ack;
    @(posedge io_clk);
    p = int'(a[7:2]);
    if (rst) begin
      for (int n = 0; n < 3; n++) m_data[n] = RV;
      m_valid = 3'b0;
      m_ovr = 3'b0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (we && p == 32 + n) begin
          if (m_valid[n] && !ack[n]) m_ovr[n] = 1'b1;
          m_data[n] = d;
          m_valid[n] = 1'b1;
        end else if (ack[n]) m_valid[n] = 1'b0;
        if (we && p == 35 && d[4 + n]) m_ovr[n] = 1'b0;
      end
    end
    @(negedge io_clk);
    bus.io_we = 1'b0; bus.out_ack = 3'b0; reset = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a; bus.io_we = 1'b0;
    #1 v = bus.io_read_data;
  endtask
  task automatic test_reset();
    logic [31:0] v;
    step(32'h0, 32'h0, 1'b0, 3'b0, 1'b1);
    step(32'h80, 32'h1111, 1'b1, 3'b111, 1'b1);
    checks++;
    if (got_state() !== {RV, RV, RV, 3'b000}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", got_state(), {RV, RV, RV, 3'b000});
    end
    rd(32'h8C, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", v); end
  endtask
  task automatic test_write();
    logic [31:0] v;
    step(32'h80, 32'hDEADBEEF, 1'b1, 3'b0, 1'b0);
    checks++;
    if (bus.out_port0 !== 32'hDEADBEEF || bus.out_valid !== 3'b001) begin
      failures++; $display("FAIL write_port0 got=%h/%b exp=deadbeef/001", bus.out_port0, bus.out_valid);
    end
    rd(32'h80, v);
    checks++;
    if (v !== 32'hDEADBEEF) begin failures++; $display("FAIL read_port0 got=%h exp=deadbeef", v); end
  endtask
  task automatic test_overrun();
    logic [31:0] v;
    step(32'h0, 32'h0, 1'b0, 3'b001, 1'b0);
    step(32'h84, 32'h1, 1'b1, 3'b0, 1'b0);
    step(32'h84, 32'h2, 1'b1, 3'b0, 1'b0);
    checks++;
    if (bus.out_port1 !== 32'h2 || bus.out_valid !== 3'b010) begin
      failures++; $display("FAIL overrun_data got=%h/%b exp=2/010", bus.out_port1, bus.out_valid);
    end
    rd(32'h8C, v);
    checks++;
    if (v !== 32'h22) begin failures++; $display("FAIL overrun_status got=%h exp=22", v); end
  endtask
  task automatic test_ack_write();
    logic [31:0] v;
    step(32'h88, 32'h3, 1'b1, 3'b0, 1'b0);
    step(32'h88, 32'h5, 1'b1, 3'b100, 1'b0);
    checks++;
    if (bus.out_port2 !== 32'h5 || bus.out_valid[2] !== 1'b1) begin
      failures++; $display("FAIL ack_write_data got=%h/%b exp=5/1", bus.out_port2, bus.out_valid[2]);
    end
    rd(32'h8C, v);
    checks++;
    if (v !== 32'h26) begin failures++; $display("FAIL ack_write_status got=%h exp=26", v); end
  endtask
  task automatic test_status_clear();
    logic [31:0] v;
    step(32'h80, 32'h1, 1'b1, 3'b0, 1'b0);
    step(32'h80, 32'h2, 1'b1, 3'b0, 1'b0);
    step(32'h8C, 32'h10, 1'b1, 3'b0, 1'b0);
    rd(32'h8C, v);
    checks++;
    if (v !== 32'h27) begin failures++; $display("FAIL status_w1c got=%h exp=27", v); end
    step(32'h0, 32'h0, 1'b0, 3'b010, 1'b0);
    step(32'h0, 32'h0, 1'b0, 3'b010, 1'b0);
    rd(32'h8C, v);
    checks++;
    if (v !== 32'h25) begin failures++; $display("FAIL stray_ack_status got=%h exp=25", v); end
    checks++;
    if (got_state() !== exp_state()) begin
      failures++; $display("FAIL stray_ack_state got=%h exp=%h", got_state(), exp_state());
    end
  endtask
  task automatic test_reset_priority();
    logic [31:0] v;
    step(32'h84, 32'h9, 1'b1, 3'b0, 1'b0);
    step(32'h80, 32'h7, 1'b1, 3'b0, 1'b1);
    checks++;
    if (got_state() !== {RV, RV, RV, 3'b000}) begin
      failures++; $display("FAIL reset_priority got=%h exp=%h", got_state(), {RV, RV, RV, 3'b000});
    end
    rd(32'h8C, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_priority_status got=%h exp=0", v); end
    rd(32'h90, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL read_90 got=%h exp=0", v); end
    rd(32'hA0, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL read_A0 got=%h exp=0", v); end
  endtask
  task automatic test_random();
    logic [5:0]  codes [7];
    logic [31:0] a, v, ra;
    codes = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h28, 6'h00};
    for (int i = 0; i < 400; i++) begin
      codes[6] = 6'($urandom());
      a = ($urandom() & 32'hFFFF_FF03) | (32'(codes[$urandom_range(0, 6)]) << 2);
      step(a, $urandom(), 1'($urandom_range(0, 1)), 3'($urandom()), $urandom_range(0, 49) == 0);
      checks++;
      if (got_state() !== exp_state()) begin
        failures++; $display("FAIL random_state i=%0d got=%h exp=%h", i, got_state(), exp_state());
      end
      ra = ($urandom() & 32'hFFFF_FF03) | (32'(codes[$urandom_range(0, 6)]) << 2);
      rd(ra, v);
      checks++;
      if (v !== exp_read(ra)) begin
        failures++; $display("FAIL random_read i=%0d addr=%h got=%h exp=%h", i, ra, v, exp_read(ra));
      end
    end
  endtask
  initial begin
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.io_we = 1'b0; bus.out_ack = 3'b0;
    test_reset();
    test_write();
    test_overrun();
    test_ack_write();
    test_status_clear();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_output.md
IO_OUTPUT -- requirements
Module: io_output

Interface
REQ-001 The block SHALL have parameter OUT_RESET, default 32'h0000_0000, which is the reset value of every out_portN data register.
REQ-002 The block SHALL have port io_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port addr, input, 32 bits: the CPU byte address; only addr[7:2] is decoded.
REQ-005 The block SHALL have port wdata, input, 32 bits: the CPU store data.
REQ-006 The block SHALL have port io_we, input, 1 bit: the CPU store strobe, one cycle per store.
REQ-007 The block SHALL have ports out_port0, out_port1 and out_port2, output, 32 bits each: the registered output data.
REQ-008 The block SHALL have port out_valid, output, 3 bits: bit N is the data-pending flag for port N.
REQ-009 The block SHALL have port out_ack, input, 3 bits: bit N is the sink-consumed pulse for port N.
REQ-010 The block SHALL have port io_read_data, output, 32 bits: combinational readback to the CPU.

Function
REQ-011 Address map on addr[7:2]: 6'b100000 (80h) = port0; 6'b100001 (84h) = port1; 6'b100010 (88h) = port2; 6'b100011 (8Ch) = STATUS.
REQ-012 On io_we=1 with a port address, the selected out_portN SHALL take wdata at that edge, visible the next cycle (1-cycle latency), and out_valid[N] SHALL be set to 1.
REQ-013 When out_valid[N]=1 and out_ack[N]=1 with no write to port N, the next edge SHALL clear out_valid[N]; out_portN holds its value.
REQ-014 When out_ack[N]=1 and out_valid[N]=0, the ack SHALL be ignored with no state change.
REQ-015 Write to port N while out_valid[N]=1 and out_ack[N]=0: the data SHALL be replaced, out_valid[N] SHALL stay 1, and sticky overrun[N] SHALL be set to 1.
REQ-016 Write to port N and out_ack[N]=1 in the same cycle: the new data SHALL be latched, out_valid[N] SHALL stay 1, and overrun[N] SHALL be unchanged.
REQ-017 STATUS read value: bits[2:0]=out_valid, bits[6:4]=overrun, all other bits 0.
REQ-018 Write to STATUS: overrun[N] SHALL be cleared where wdata[4+N]=1 (write-1-to-clear); out_valid and the data registers SHALL be unaffected.
REQ-019 A same-cycle STATUS clear and a new overrun on the same bit SHALL resolve as set.
REQ-020 io_read_data (combinational): 80h/84h/88h return out_portN; 8Ch returns STATUS; any other addr[7:2] (including 90h) returns 32'h0.
REQ-021 io_we=1 with an unmapped address SHALL cause no state change.
REQ-022 The block SHALL decode no address bits above bit 7 and SHALL NOT depend on addr[1:0].

Reset
REQ-023 While reset=1 at a rising edge: out_port0..2 SHALL be set to OUT_RESET, out_valid to 3'b000 and overrun to 3'b000.
REQ-024 Reset SHALL take priority over io_we and out_ack in the same cycle; a write pending in that cycle is discarded.
REQ-025 Reset asserted mid-handshake SHALL drop out_valid without requiring out_ack.
REQ-026 The block SHALL contain no initial blocks and no asynchronous reset paths.

Structure
REQ-027 The shared I/O package SHALL hold the 6-bit address codes (port0..2, STATUS, and input 90h) and the STATUS bit positions.
REQ-028 One sub-module SHALL be io_out_chan (data register, valid, overrun; inputs: we, ack, clr, wdata), instantiated three times.
REQ-029 The top level SHALL contain only the address decode, the readback mux and STATUS assembly.

Verification
REQ-030 Reset, then write 80h <- 32'hDEADBEEF -> out_port0=DEADBEEF and out_valid=3'b001 next cycle; io_read_data at 80h = DEADBEEF.
REQ-031 Pending port1 (84h <- 1), second write 84h <- 2 with no ack -> out_port1=2, valid[1]=1, STATUS=32'h0000_0022.
REQ-032 Pending port2 with out_ack[2]=1 and write 88h <- 5 in the same cycle -> out_port2=5, valid[2]=1, overrun[2]=0.
REQ-033 Overrun on port0, write 8Ch <- 32'h10 -> STATUS bit4=0 and valid bit0 unchanged; stray out_ack on an idle port -> no change.
REQ-034 Reset asserted with all valids set and a simultaneous write 80h <- 7 -> all outputs = OUT_RESET, valid=0, overrun=0; read of 90h or A0h = 0.
